rggen_wishbone_slave_adapter: RTL

//  Pipelined Wishbone B4 slave that buffers requests and replays them on an rggen

---
 rtl/rggen_wishbone_slave_adapter.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/rggen_wishbone_slave_adapter.sv
// rtl/rggen_wishbone_slave_adapter.sv - pipelined Wishbone B4 slave replaying requests on an rggen native bus
module rggen_wishbone_slave_adapter #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int DEPTH         = 4,
  parameter int TIMEOUT       = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wb_cyc,
  input  logic                     i_wb_stb,
  output logic                     o_wb_stall,
  input  logic [ADDRESS_WIDTH-1:0] i_wb_adr,
  input  logic                     i_wb_we,
  input  logic [BUS_WIDTH-1:0]     i_wb_dat,
  input  logic [BUS_WIDTH/8-1:0]   i_wb_sel,
  output logic                     o_wb_ack,
  output logic                     o_wb_err,
  output logic                     o_wb_rty,
  output logic [BUS_WIDTH-1:0]     o_wb_dat,
  output logic                     o_bus_valid,
  output logic [1:0]               o_bus_access,
  output logic [ADDRESS_WIDTH-1:0] o_bus_address,
  output logic [BUS_WIDTH-1:0]     o_bus_write_data,
  output logic [BUS_WIDTH/8-1:0]   o_bus_strobe,
  input  logic                     i_bus_ready,
  input  logic [1:0]               i_bus_status,
  input  logic [BUS_WIDTH-1:0]     i_bus_read_data
);

  localparam int STROBE_WIDTH = BUS_WIDTH / 8;
  localparam int PTR_WIDTH    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_WIDTH    = $clog2(DEPTH + 1);
  localparam int TMO_WIDTH    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int ENTRY_WIDTH  = 1 + ADDRESS_WIDTH + BUS_WIDTH + STROBE_WIDTH;

  localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);
  localparam logic [TMO_WIDTH-1:0] TMO_LIMIT  = TMO_WIDTH'(TIMEOUT);

  // rggen access / status encodings
  localparam logic [1:0] ACCESS_READ   = 2'b10;
  localparam logic [1:0] ACCESS_WRITE  = 2'b11;
  localparam logic [1:0] STATUS_OKAY   = 2'b00;
  localparam logic [1:0] STATUS_EXOKAY = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                   state_q, state_d;

  logic [ENTRY_WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_WIDTH-1:0]     wr_ptr_q;
  logic [PTR_WIDTH-1:0]     rd_ptr_q;
  logic [CNT_WIDTH-1:0]     count_q;

  logic                     valid_q, valid_d;
  logic                     ack_q, ack_d;
  logic                     err_q, err_d;
  logic [BUS_WIDTH-1:0]     rdat_q, rdat_d;
  logic [TMO_WIDTH-1:0]     tmo_q, tmo_d;

  logic [1:0]               access_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic [BUS_WIDTH-1:0]     wdata_q;
  logic [STROBE_WIDTH-1:0]  strobe_q;

  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;
  logic                     timeout;
  logic                     resp_ok;
  logic                     done;
  logic [ENTRY_WIDTH-1:0]   head;

  // Stall comes only from the registered count, so a pop never opens a slot in the same cycle
  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign push    = i_wb_cyc & i_wb_stb & ~full;
  assign head    = mem_q[rd_ptr_q];
  assign timeout = (TIMEOUT > 0) && valid_q && (tmo_q == TMO_LIMIT);
  assign resp_ok = (i_bus_status == STATUS_OKAY) || (i_bus_status == STATUS_EXOKAY);
  assign done    = i_bus_ready | timeout;

  assign o_wb_stall       = full;
  assign o_wb_ack         = ack_q;
  assign o_wb_err         = err_q;
  assign o_wb_rty         = 1'b0;
  assign o_wb_dat         = rdat_q;
  assign o_bus_valid      = valid_q;
  assign o_bus_access     = access_q;
  assign o_bus_address    = address_q;
  assign o_bus_write_data = wdata_q;
  assign o_bus_strobe     = strobe_q;

  // FIFO storage; entries are {we, adr, dat, sel}
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {i_wb_we, i_wb_adr, i_wb_dat, i_wb_sel};
    end
  end

  // FIFO pointers and occupancy; dropping cyc discards everything queued
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (!i_wb_cyc) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state, pop decision, response generation and timeout counting
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    valid_d = valid_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdat_d  = '0;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (i_wb_cyc && !empty) begin
          pop     = 1'b1;
          valid_d = 1'b1;
          tmo_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!i_wb_cyc) begin
          // Master abandoned the cycle: finish the bus access silently
          if (done) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end else begin
            tmo_d   = tmo_q + 1'b1;
            state_d = DRAIN;
          end
        end else if (i_bus_ready) begin
          ack_d  = resp_ok;
          err_d  = ~resp_ok;
          rdat_d = (resp_ok && (access_q == ACCESS_READ)) ? i_bus_read_data : '0;
          if (!empty) begin
            pop     = 1'b1;
            valid_d = 1'b1;
            tmo_d   = '0;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DRAIN: begin
        if (done) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Response and timeout registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
      tmo_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
      tmo_q   <= tmo_d;
    end
  end

  // Request fields are loaded only on pop, keeping them stable while valid is high
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      access_q  <= 2'b00;
      address_q <= '0;
      wdata_q   <= '0;
      strobe_q  <= '0;
    end else if (pop) begin
      access_q  <= head[ENTRY_WIDTH-1] ? ACCESS_WRITE : ACCESS_READ;
      address_q <= head[ENTRY_WIDTH-2 -: ADDRESS_WIDTH];
      wdata_q   <= head[BUS_WIDTH+STROBE_WIDTH-1 -: BUS_WIDTH];
      strobe_q  <= head[STROBE_WIDTH-1:0];
    end
  end

endmodule
